// File: rtl/rr_arbiter.sv
// N-channel round-robin arbiter with bounded grant hold time.
// Optional ARB_LOCK_EN adds a lock input that suppresses hold expiry.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
`ifdef ARB_LOCK_EN
  input  logic                 lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int HCW = (HW < 1) ? 1 : HW;
  localparam logic [HCW-1:0] HSAT =
    (MAX_HOLD == 0) ? {HCW{1'b1}} : HCW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] id_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [IDW-1:0] nxt;
  logic [IDW-1:0] sel;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic           expired;

  // first set bit scanning cyclically upward from p
  function automatic logic [IDW-1:0] pick(
    input logic [N-1:0]   r,
    input logic [IDW-1:0] p
  );
    logic [IDW-1:0] s;
    logic [IDW:0]   k;
    logic           f;
    s = '0;
    f = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, p} + (IDW+1)'(i);
      if (k >= (IDW+1)'(N)) k = k - (IDW+1)'(N);
      if (!f && r[k[IDW-1:0]]) begin
        f = 1'b1;
        s = k[IDW-1:0];
      end
    end
    return s;
  endfunction

  assign nxt = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    expired = (MAX_HOLD != 0) && (hold_cnt >= HSAT);
`ifdef ARB_LOCK_EN
    if (lock && req[gnt_id]) expired = 1'b0;
`endif
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    sel     = '0;
    case (state)
      IDLE: begin
        if (|req) begin
          sel     = pick(req, ptr);
          state_n = GRANT;
          id_n    = sel;
          gnt_n   = '0;
          gnt_n[sel] = 1'b1;
          hold_n  = HCW'(1);
        end
      end
      GRANT: begin
        if (req[gnt_id] && !expired) begin
          if (hold_cnt != HSAT) hold_n = hold_cnt + 1'b1;
        end else begin
          // release: rotate past owner, re-arbitrate on same edge
          ptr_n = nxt;
          if (|req) begin
            sel    = pick(req, nxt);
            id_n   = sel;
            gnt_n  = '0;
            gnt_n[sel] = 1'b1;
            hold_n = HCW'(1);
          end else begin
            state_n = IDLE;
            id_n    = '0;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        id_n    = '0;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= id_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign gnt_valid = |gnt;

endmodule
